// File: rtl/mem_pkg.sv
// Shared types and default geometry for the 512x32 memory responder.
`default_nettype none

package mem_pkg;
  localparam int MEM_DEPTH  = 512;
  localparam int MEM_ADDR_W = 9;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/ram_sp_512x32.sv
// Single-port synchronous RAM, read-first, with registered read data.
`default_nettype none

module ram_sp_512x32 #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end
endmodule

`default_nettype wire

// File: rtl/memory_unit_512x32.sv
// Word-addressed 512x32 memory responder with wait states and a one-cycle ready pulse.
// Optional bounds checking on in_addr[31:ADDR_W] is enabled by MEM_BOUNDS_CHECK_EN.
`default_nettype none

module memory_unit_512x32
  import mem_pkg::*;
#(
  parameter int DEPTH       = MEM_DEPTH,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_read,
  input  logic        in_write,
  output logic [31:0] out_rdata,
  output logic        out_ready,
  output logic        out_busy,
  output logic        out_error
);
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, ram_idx;
  logic [31:0]       wdata_q, ram_wd, ram_q, rdata_hold, rd_done;
  logic              wr_q, oob_q, oob_now, oob_eff, op_wr;
  logic              req, access, ram_we;

  assign req = in_read | in_write;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_now   = |in_addr[31:ADDR_W];
  assign out_error = (state == DONE) & oob_q;
`else
  logic unused_upper;
  assign unused_upper = |in_addr[31:ADDR_W];
  assign oob_now      = 1'b0;
  assign out_error    = 1'b0;
`endif

  // WAIT lasts WAIT_CYCLES cycles: the access fires on the edge that takes the counter to 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the live inputs feed the array so a zero-wait access completes on the sampling edge.
  always_comb begin
    if (state == IDLE) begin
      ram_idx = in_addr[ADDR_W-1:0];
      ram_wd  = in_wdata;
      op_wr   = in_write;
      oob_eff = oob_now;
    end else begin
      ram_idx = addr_q;
      ram_wd  = wdata_q;
      op_wr   = wr_q;
      oob_eff = oob_q;
    end
  end

  assign ram_we = access & op_wr & ~oob_eff;

  ram_sp_512x32 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      oob_q      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        addr_q  <= in_addr[ADDR_W-1:0];
        wdata_q <= in_wdata;
        wr_q    <= in_write;
        oob_q   <= oob_now;
      end
      if (state == DONE && !wr_q) begin
        rdata_hold <= rd_done;
      end
    end
  end

  // Read data is presented straight from the array register during DONE, then held.
  assign rd_done   = oob_q ? 32'd0 : ram_q;
  assign out_rdata = (state == DONE && !wr_q) ? rd_done : rdata_hold;
  assign out_ready = (state == DONE);
  assign out_busy  = (state != IDLE);
endmodule

`default_nettype wire
